dmem_access_arbiter: RTL
========================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-port data memory between the MEM stage (requester P) and the
//  debug/program loader (requester D). Round-robin arbitration, fixed-latency access
//  sequencing, one-cycle ack per transaction, stall back to the pipeline. Sits between
//  the EX/MEM register and data_memory.
// PARAMETERS
//  ADDR_W   32  address width, passed through unchanged to memory
//  DATA_W   32  data width
//  MEM_LAT  2   cycles an access is held on the memory port (legal range 1..15)
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       synchronous, active-high
//  p_req    in   1       MEM-stage request, held until p_ack
//  p_we     in   1       1 = write, 0 = read
//  p_addr   in   ADDR_W  MEM-stage address
//  p_wdata  in   DATA_W  MEM-stage write data
//  p_rdata  out  DATA_W  read data, valid in the p_ack cycle
//  p_ack    out  1       one-cycle completion pulse to P
//  stall    out  1       p_req & ~p_ack, combinational, freezes the pipeline
//  d_req, d_we, d_addr, d_wdata, d_rdata, d_ack: loader port, same widths and rules as P
//  m_addr   out  ADDR_W  to data_memory Address
//  m_wdata  out  DATA_W  to data_memory WriteData
//  m_read   out  1       to data_memory MemRead
//  m_write  out  1       to data_memory MemWrite, single-cycle pulse
//  m_rdata  in   DATA_W  from data_memory ReadData
// BEHAVIOUR
//  Reset: state=IDLE; last_grant=D, so P wins the first tie; cnt=0.
//   m_read=m_write=p_ack=d_ack=0; m_addr=m_wdata=p_rdata=d_rdata=0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE:
//   - No request: stay.
//   - Exactly one request: grant that requester.
//   - Both requesting: grant the requester not equal to last_grant.
//   - On grant: register addr, wdata and we from the granted port; update last_grant;
//     cnt=MEM_LAT-1; go to ACCESS.
//  ACCESS:
//   - Drive m_addr and m_wdata from the registered values.
//   - Read: m_read=1 in every ACCESS cycle.
//   - Write: m_write=1 only in the first ACCESS cycle, giving one rising edge per write.
//   - cnt decrements each cycle; at cnt==0, capture m_rdata for reads and go to DONE.
//  DONE:
//   - Pulse the granted ack for one cycle; the granted rdata holds the captured word.
//   - Writes return rdata=0.
//   - m_read=m_write=0. Next state is IDLE.
//  Latency: req seen in IDLE at cycle t gives ack at cycle t+MEM_LAT+1.
//   - Minimum spacing between accesses is MEM_LAT+2 cycles.
//  Ungranted rdata and ack stay 0. rdata of the last granted port holds until its next grant.
//  Requests must stay stable until ack:
//   - A request dropped mid-transaction still completes and pulses ack.
//   - Request inputs are sampled only in IDLE.
//  Request raised in DONE: considered in the following IDLE cycle, not before.
//  Reset mid-ACCESS: abort to IDLE in the next cycle with all outputs at reset values; no ack.
//   - A write whose m_write pulse already fired is not undone.
//  Addresses are passed through unmodified; the memory decodes addr[7:0].
// TESTING
//  1 Reset, P read addr 4, MEM_LAT=2 (mem[4]=ABCDEF01) -> m_read high 2 cycles,
//    p_ack at t+3, p_rdata=ABCDEF01, stall high t..t+2.
//  2 P write addr 8 data 12345678, then P read addr 8 -> exactly one m_write pulse;
//    read returns 12345678.
//  3 P and D request together from reset -> P granted first, D acked MEM_LAT+2 cycles
//    after P; while both are held continuously, grants alternate P,D,P,D.
//  4 D write addr 16 = DEADBEEF while P idle -> d_ack once, p_ack stays 0, p_rdata unchanged.
//  5 reset asserted in 2nd ACCESS cycle of a read -> next cycle IDLE, no ack, m_read=0;
//    next request completes normally.
//  6 MEM_LAT=1: back-to-back P reads of addr 0,1 -> acks exactly 3 cycles apart, data correct.

Source files
------------

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
// Shares the single-port data memory between the MEM stage (P) and the
// debug/program loader (D). Round-robin grant, fixed-latency access on the
// memory port, a one-cycle ack per transaction and a stall back to the pipeline.
module dmem_access_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  // MEM-stage requester
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_ack,
  output logic              stall,
  // loader requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // data_memory side
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata
);

  // Counter load value: the access occupies MEM_LAT cycles, counting down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1 when the loader held the most recent grant
  logic              gnt_d_q, gnt_d_d;     // 1 when the current transaction is the loader's
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Next-state, grant and memory-port outputs for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets its default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    m_addr    = '0;
    m_wdata   = '0;
    m_read    = 1'b0;
    m_write   = 1'b0;
    p_ack     = 1'b0;
    d_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (p_req || d_req) begin
          // On a tie the requester that did not win last time goes first.
          gnt_d_d  = d_req && (!p_req || !last_d_q);
          last_d_d = gnt_d_d;
          addr_d   = gnt_d_d ? d_addr  : p_addr;
          wdata_d  = gnt_d_d ? d_wdata : p_wdata;
          we_d     = gnt_d_d ? d_we    : p_we;
          cnt_d    = CNT_LOAD;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_read  = !we_q;
        // Only the first access cycle writes, so each write is a single edge.
        m_write = we_q && (cnt_q == CNT_LOAD);
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (gnt_d_q) d_rdata_d = we_q ? '0 : m_rdata;
          else         p_rdata_d = we_q ? '0 : m_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        p_ack   = !gnt_d_q;
        d_ack   = gnt_d_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset also aborts an access.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      gnt_d_q   <= 1'b0;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign p_rdata = p_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = p_req & ~p_ack;

endmodule
